// File: rtl/pong_game_ctrl_if.sv
// Pong controller bundle: paddle/frame/collision inputs, freeze/state/score outputs.
// The master drives the inputs and the slave (the controller) drives the display-side outputs.
interface pong_game_ctrl_if;
  logic [1:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic [1:0] game_state;
  logic [1:0] balls_left;
  logic [3:0] score_d1;
  logic [3:0] score_d0;

  modport master (
    output btn, refr_tick, hit, miss,
    input  gra_still, game_state, balls_left, score_d1, score_d0
  );

  modport slave (
    input  btn, refr_tick, hit, miss,
    output gra_still, game_state, balls_left, score_d1, score_d0
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: NEWGAME/PLAY/NEWBALL/OVER FSM with BCD score, ball count and frame-tick hold timer.
// All outputs registered (one-edge latency from inputs); no backpressure, inputs are sampled every cycle.
module pong_game_ctrl #(
  parameter int BALLS      = 3,
  parameter int WAIT_TICKS = 120
) (
  input  logic            clk,
  input  logic            reset,
  pong_game_ctrl_if.slave gi
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic [1:0] BALLS_INIT = 2'(BALLS);
  localparam logic [7:0] WAIT_INIT  = 8'(WAIT_TICKS);

  state_t     state_q,     state_d;
  logic       gra_still_q, gra_still_d;
  logic [1:0] balls_q,     balls_d;
  logic [3:0] d1_q,        d1_d;
  logic [3:0] d0_q,        d0_d;
  logic [7:0] timer_q,     timer_d;

  logic pressed;
  assign pressed = (gi.btn != 2'b00);

  always_comb begin
    state_d = state_q;
    balls_d = balls_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    timer_d = timer_q;

    case (state_q)
      NEWGAME: begin
        // Score and ball count stay frozen here so the last result remains visible.
        if (pressed) begin
          state_d = PLAY;
          balls_d = BALLS_INIT;
          d1_d    = 4'd0;
          d0_d    = 4'd0;
        end
      end

      PLAY: begin
        if (gi.hit) begin
          if (d0_q == 4'd9) begin
            d0_d = 4'd0;
            d1_d = (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
          end else begin
            d0_d = d0_q + 4'd1;
          end
        end
        // A miss coinciding with a hit still takes effect; the score update above is kept.
        if (gi.miss) begin
          timer_d = WAIT_INIT;
          if (balls_q > 2'd1) begin
            balls_d = balls_q - 2'd1;
            state_d = NEWBALL;
          end else begin
            balls_d = 2'd0;
            state_d = OVER;
          end
        end
      end

      NEWBALL: begin
        if (timer_q == 8'd0) begin
          if (pressed) state_d = PLAY;
        end else if (gi.refr_tick) begin
          timer_d = timer_q - 8'd1;
        end
      end

      OVER: begin
        // Exit is one edge after the tick that empties the timer; buttons have no effect.
        if (timer_q == 8'd0) begin
          state_d = NEWGAME;
        end else if (gi.refr_tick) begin
          timer_d = timer_q - 8'd1;
        end
      end

      default: state_d = NEWGAME;
    endcase

    gra_still_d = (state_d != PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= NEWGAME;
      gra_still_q <= 1'b1;
      balls_q     <= BALLS_INIT;
      d1_q        <= 4'd0;
      d0_q        <= 4'd0;
      timer_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      gra_still_q <= gra_still_d;
      balls_q     <= balls_d;
      d1_q        <= d1_d;
      d0_q        <= d0_d;
      timer_q     <= timer_d;
    end
  end

  assign gi.gra_still  = gra_still_q;
  assign gi.game_state = state_q;
  assign gi.balls_left = balls_q;
  assign gi.score_d1   = d1_q;
  assign gi.score_d0   = d0_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with default BALLS=3, WAIT_TICKS=120.
module tb_pong_game_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  pong_game_ctrl_if gi();

  pong_game_ctrl #(.BALLS(3), .WAIT_TICKS(120)) dut (
    .clk   (clk),
    .reset (reset),
    .gi    (gi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int still,
                         input int bl, input int d1, input int d0);
    chk({tag, ".state"}, int'(gi.game_state), st);
    chk({tag, ".still"}, int'(gi.gra_still), still);
    chk({tag, ".balls"}, int'(gi.balls_left), bl);
    chk({tag, ".d1"},    int'(gi.score_d1), d1);
    chk({tag, ".d0"},    int'(gi.score_d0), d0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      gi.hit = 1'b1;
      step();
      gi.hit = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      gi.refr_tick = 1'b1;
      step();
      gi.refr_tick = 1'b0;
    end
  endtask

  // Miss from PLAY, full countdown with the button held, then the return edge.
  task automatic miss_and_return();
    gi.miss = 1'b1;
    step();
    gi.miss = 1'b0;
    ticks(120);
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset        = 1'b1;
    gi.btn       = 2'b00;
    gi.refr_tick = 1'b0;
    gi.hit       = 1'b0;
    gi.miss      = 1'b0;

    step();
    step();
    chk_all("reset", 0, 1, 3, 0, 0);
    reset = 1'b0;
    step();
    chk_all("idle_newgame", 0, 1, 3, 0, 0);

    // Collisions outside PLAY are ignored.
    gi.hit = 1'b1; gi.miss = 1'b1;
    step();
    gi.hit = 1'b0; gi.miss = 1'b0;
    chk_all("newgame_hitmiss", 0, 1, 3, 0, 0);

    gi.btn = 2'b01;
    step();
    gi.btn = 2'b00;
    chk_all("start", 1, 0, 3, 0, 0);

    hits(12);
    chk_all("score12", 1, 0, 3, 1, 2);
    hits(87);
    chk_all("score99", 1, 0, 3, 9, 9);
    hits(1);
    chk_all("score_wrap", 1, 0, 3, 0, 0);

    // First miss with button held through the countdown.
    gi.btn  = 2'b10;
    gi.miss = 1'b1;
    step();
    gi.miss = 1'b0;
    chk_all("miss1", 2, 1, 2, 0, 0);
    ticks(119);
    chk_all("nb_tick119", 2, 1, 2, 0, 0);
    ticks(1);
    chk_all("nb_tick120", 2, 1, 2, 0, 0);
    step();
    chk_all("nb_exit", 1, 0, 2, 0, 0);
    gi.btn = 2'b00;

    // Coincident hit and miss at score 09.
    hits(9);
    chk_all("score09", 1, 0, 2, 0, 9);
    gi.hit = 1'b1; gi.miss = 1'b1;
    step();
    gi.hit = 1'b0; gi.miss = 1'b0;
    chk_all("hit_miss", 2, 1, 1, 1, 0);
    hits(1);
    gi.miss = 1'b1;
    step();
    gi.miss = 1'b0;
    chk_all("nb_ignore", 2, 1, 1, 1, 0);
    ticks(120);
    step(); step(); step();
    chk_all("nb_wait_btn", 2, 1, 1, 1, 0);
    gi.btn = 2'b01;
    step();
    gi.btn = 2'b00;
    chk_all("nb_btn", 1, 0, 1, 1, 0);

    // Last ball: OVER, button ignored, then back to NEWGAME with score shown.
    gi.btn  = 2'b11;
    gi.miss = 1'b1;
    step();
    gi.miss = 1'b0;
    chk_all("miss_last", 3, 1, 0, 1, 0);
    ticks(119);
    chk_all("over_tick119", 3, 1, 0, 1, 0);
    ticks(1);
    chk_all("over_tick120", 3, 1, 0, 1, 0);
    gi.btn = 2'b00;
    step();
    chk_all("over_exit", 0, 1, 0, 1, 0);
    step(); step();
    chk_all("final_hold", 0, 1, 0, 1, 0);
    gi.btn = 2'b01;
    step();
    chk_all("restart", 1, 0, 3, 0, 0);

    // Reach OVER with timer at 50, then reset alongside every other input.
    hits(5);
    miss_and_return();
    chk_all("ret1", 1, 0, 2, 0, 5);
    miss_and_return();
    chk_all("ret2", 1, 0, 1, 0, 5);
    gi.miss = 1'b1;
    step();
    gi.miss = 1'b0;
    gi.btn  = 2'b00;
    ticks(70);
    chk_all("over_t50", 3, 1, 0, 0, 5);
    reset = 1'b1; gi.hit = 1'b1; gi.miss = 1'b1; gi.refr_tick = 1'b1; gi.btn = 2'b11;
    step();
    reset = 1'b0; gi.hit = 1'b0; gi.miss = 1'b0; gi.refr_tick = 1'b0; gi.btn = 2'b00;
    chk_all("mid_reset", 0, 1, 3, 0, 0);
    step();
    chk_all("post_reset", 0, 1, 3, 0, 0);
    gi.btn = 2'b10;
    step();
    gi.btn = 2'b00;
    chk_all("post_start", 1, 0, 3, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter BALLS, default 3: balls per game, legal range 1-3.
REQ-002 SHALL have parameter WAIT_TICKS, default 120: frame ticks to hold after a miss, legal range 1-255.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port btn, input, 2 bits: paddle buttons, level-sensitive; "pressed" means btn != 2'b00.
REQ-006 SHALL have port refr_tick, input, 1 bit: one-cycle pulse once per video frame.
REQ-007 SHALL have port hit, input, 1 bit: one-cycle pulse when the ball strikes the paddle.
REQ-008 SHALL have port miss, input, 1 bit: one-cycle pulse when the ball passes the paddle.
REQ-009 SHALL have port gra_still, output, 1 bit: 1 = graphics frozen, ball parked at its start position.
REQ-010 SHALL have port game_state, output, 2 bits: current state encoding, 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
REQ-011 SHALL have port balls_left, output, 2 bits: balls remaining, unsigned.
REQ-012 SHALL have port score_d1, output, 4 bits: BCD tens digit of the score.
REQ-013 SHALL have port score_d0, output, 4 bits: BCD units digit of the score.

Function
REQ-014 SHALL implement a four-state FSM: NEWGAME, PLAY, NEWBALL, OVER; all outputs registered, no combinational input-to-output path.
REQ-015 SHALL assert gra_still in NEWGAME, NEWBALL and OVER, and deassert it only in PLAY; gra_still and game_state change on the same edge as the state.
REQ-016 NEWGAME: on the first cycle with btn pressed, go to PLAY, load balls_left=BALLS and clear score to 00 on that same edge.
REQ-017 PLAY, hit pulse: increment the score as two-digit BCD; d0 9->0 carries into d1; 99 wraps to 00.
REQ-018 PLAY, miss pulse with balls_left>1: decrement balls_left, load an 8-bit timer with WAIT_TICKS, go to NEWBALL.
REQ-019 PLAY, miss pulse with balls_left==1: set balls_left=0, load the timer with WAIT_TICKS, go to OVER.
REQ-020 PLAY, hit and miss in the same cycle: apply both, i.e. score increments and the miss transition occurs.
REQ-021 NEWBALL: decrement the timer by 1 on each refr_tick while it is nonzero.
REQ-022 NEWBALL exit: go to PLAY on the first cycle with timer==0 and btn pressed; a button held during the countdown is honoured as soon as timer==0.
REQ-023 OVER: decrement the timer on each refr_tick; when the timer reaches 0, go to NEWGAME on the next edge; btn is ignored in OVER.
REQ-024 SHALL hold score and balls_left unchanged in NEWGAME until the PLAY transition, so the final score remains displayable.
REQ-025 SHALL ignore hit and miss in every state other than PLAY.
REQ-026 When a timer load and a refr_tick coincide, the load SHALL win; the timer never underflows below 0.
REQ-027 SHALL never take a state transition and a timer decrement on the same edge from the same timer value.

Reset
REQ-028 With reset=1 at a clk edge, the block SHALL enter NEWGAME with gra_still=1, game_state=00, balls_left=BALLS, score_d1=0, score_d0=0, timer=0.
REQ-029 Reset SHALL override all inputs, including reset asserted mid-countdown in NEWBALL/OVER or coincident with hit/miss; the first post-reset edge evaluates NEWGAME rules.

Verification
REQ-030 Reset then btn=01 for 1 cycle -> next edge: game_state=01, gra_still=0, balls_left=3, score=00.
REQ-031 In PLAY, 12 hit pulses -> score_d1=1, score_d0=2; 100 hits from 00 -> score 00 (wrap).
REQ-032 In PLAY with balls_left=3, miss -> NEWBALL, balls_left=2, gra_still=1; btn held throughout -> PLAY exactly on the edge after the 120th refr_tick zeroes the timer.
REQ-033 Third miss -> OVER, balls_left=0; after 120 refr_ticks -> NEWGAME, score still shown; btn then -> PLAY, score=00, balls_left=3.
REQ-034 hit+miss same cycle at score 09, balls_left=2 -> score 10, balls_left=1, NEWBALL; hit/miss pulses in NEWBALL -> no change.
REQ-035 reset asserted during an OVER countdown with timer=50 -> NEWGAME, timer=0, all outputs at reset values next edge.
